eeg_spi_frame_reader: RTL

- SPI master that reads one conversion frame from the 24-bit multichannel EEG ADC each time the ADC's data-ready line falls.
- Frame layout: one 24-bit status word, then NUM_CH 24-bit channel words.
- Each channel word is presented as a 24-bit signed sample with a one-cycle data_valid pulse. This is the producing end of the raw_eeg_in / data_valid interface consumed by boreal_apex_core.
- Sits between the ADC pins and the neuro-core.

---
 rtl/eeg_spi_frame_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/eeg_spi_frame_reader.sv
// SPI master that pulls one status word plus NUM_CH signed 24-bit channel words
// from the EEG ADC on every data-ready fall, strobing each channel out in turn.
module eeg_spi_frame_reader #(
  parameter int CLK_DIV = 4,
  parameter int NUM_CH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               adc_drdy_n,
  input  logic               adc_miso,
  output logic               adc_cs_n,
  output logic               adc_sclk,
  output logic               adc_mosi,
  output logic signed [23:0] raw_eeg_out,
  output logic [2:0]         ch_idx,
  output logic               data_valid,
  output logic [23:0]        status_word,
  output logic               frame_done,
  output logic               overrun
);

  localparam int WORD_W = 24;
  localparam int CW     = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e              state_q;
  logic                sync1_q, sync2_q, drdy_prev_q;
  logic [CW-1:0]       div_q;
  logic [4:0]          bit_q;
  logic [3:0]          word_q;
  logic                pend_q;
  logic [3:0]          pend_word_q;
  logic [WORD_W-1:0]   shift_q;
  logic [WORD_W-1:0]   shift_d;
  logic                drdy_fall;
  logic                div_end;
  logic                last_bit;
  logic                shift_en;

  assign adc_mosi  = 1'b0;
  assign drdy_fall = drdy_prev_q & ~sync2_q;
  assign div_end   = (div_q == CW'(CLK_DIV - 1));
  assign last_bit  = (bit_q == 5'd23) && (word_q == 4'(NUM_CH));
  assign shift_en  = (state_q == SHIFT) && adc_sclk && div_end;
  assign shift_d   = {shift_q[WORD_W-2:0], adc_miso};

  // MISO is captured on the cycle SCLK drops, i.e. the ADC's falling edge.
  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= shift_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      drdy_prev_q <= 1'b1;
      div_q       <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      adc_cs_n    <= 1'b1;
      adc_sclk    <= 1'b0;
      raw_eeg_out <= '0;
      ch_idx      <= '0;
      data_valid  <= 1'b0;
      status_word <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync1_q     <= adc_drdy_n;
      sync2_q     <= sync1_q;
      drdy_prev_q <= sync2_q;
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;

      // A completed word is published one cycle after its last bit lands.
      if (pend_q) begin
        pend_q <= 1'b0;
        if (pend_word_q == 4'd0) begin
          status_word <= shift_q;
        end else begin
          raw_eeg_out <= shift_q;
          ch_idx      <= 3'(pend_word_q - 4'd1);
          data_valid  <= 1'b1;
          frame_done  <= (pend_word_q == 4'(NUM_CH));
        end
      end

      if (drdy_fall && (state_q != IDLE)) overrun <= 1'b1;

      case (state_q)
        IDLE: begin
          div_q  <= '0;
          bit_q  <= '0;
          word_q <= '0;
          if (!enable) begin
            overrun <= 1'b0;
          end else if (drdy_fall) begin
            state_q  <= SETUP;
            adc_cs_n <= 1'b0;
          end
        end
        SETUP: begin
          if (div_end) begin
            div_q    <= '0;
            adc_sclk <= 1'b1;
            state_q  <= SHIFT;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (adc_sclk) begin
              adc_sclk <= 1'b0;
              if (bit_q == 5'd23) begin
                pend_q      <= 1'b1;
                pend_word_q <= word_q;
              end
            end else if (last_bit) begin
              state_q <= HOLD;
            end else begin
              adc_sclk <= 1'b1;
              if (bit_q == 5'd23) begin
                bit_q  <= '0;
                word_q <= word_q + 4'd1;
              end else begin
                bit_q <= bit_q + 5'd1;
              end
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            div_q    <= '0;
            adc_cs_n <= 1'b1;
            state_q  <= IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
